led_scheduler: RTL and testbench

Owner and scheduler of the 10-bit LEDR bank on the board top. Multiplexes three requesters onto the LEDs under a fixed priority: a KEY-triggered lamp test, the processor's `leds` write port, and a free-running 1 Hz heartbeat counter. Also synchronizes and debounces the four raw KEY inputs and exports the debounced levels for other top-level logic.

---
 rtl/led_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_led_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/led_scheduler.sv
// LEDR bank owner: arbitrates lamp test, processor writes and a 1 Hz heartbeat
// onto ten LEDs, and exports synchronized, debounced KEY levels.
module led_scheduler #(
    parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int HOLD_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    input  logic [9:0] proc_leds,
    input  logic       proc_wr,
    output logic [9:0] leds,
    output logic [1:0] src,
    output logic [3:0] keys_pressed,
    output logic       tick
);

    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DEB_W  = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);

    typedef enum logic [1:0] {
        ST_HB   = 2'd0,
        ST_PROC = 2'd1,
        ST_TEST = 2'd2
    } state_t;

    logic [DIV_W-1:0]            div_r, div_s;
    logic                        tick_r;
    logic [3:0]                  sync1_r, sync2_r;
    logic [3:0]                  db_r, db_s;
    logic [3:0][DEB_W-1:0]       cnt_r, cnt_s;
    logic [3:0]                  kp_r, kp_s;
    logic [9:0]                  hb_r, hb_s;
    logic [9:0]                  proc_q_r, proc_q_s;
    logic [HOLD_W-1:0]           hold_r, hold_s;
    logic                        pat_r, pat_s;
    state_t                      state_r, state_s;
    logic [9:0]                  leds_r, leds_s;
    logic [1:0]                  src_r, src_s;

    // Tick divider next value
    always_comb begin
        div_s = div_r;
        if (div_r == DIV_LAST) begin
            div_s = '0;
        end else begin
            div_s = div_r + DIV_W'(1'b1);
        end
    end

    // Debouncers: accept the synced level once it has differed for DEB_CYCLES cycles
    always_comb begin
        db_s  = db_r;
        cnt_s = cnt_r;
        for (int i = 0; i < 4; i++) begin
            if (sync2_r[i] == db_r[i]) begin
                cnt_s[i] = '0;
            end else if (cnt_r[i] == DEB_LAST) begin
                db_s[i]  = sync2_r[i];
                cnt_s[i] = '0;
            end else begin
                cnt_s[i] = cnt_r[i] + DEB_W'(1'b1);
            end
        end
        kp_s = ~db_s;
    end

    // Heartbeat and processor latch; the key-0 clear beats a tick, a write beats a decrement
    always_comb begin
        hb_s     = hb_r;
        proc_q_s = proc_q_r;
        hold_s   = hold_r;
        if (kp_s[0]) begin
            hb_s = 10'd0;
        end else if (tick_r) begin
            hb_s = hb_r + 10'd1;
        end else begin
            hb_s = hb_r;
        end
        if (proc_wr) begin
            proc_q_s = proc_leds;
            hold_s   = HOLD_LOAD;
        end else if (tick_r && (hold_r != '0)) begin
            hold_s = hold_r - HOLD_W'(1'b1);
        end else begin
            hold_s = hold_r;
        end
    end

    // Next state from next-cycle key and hold values
    always_comb begin
        state_s = ST_HB;
        if (kp_s[1]) begin
            state_s = ST_TEST;
        end else if (hold_s != '0) begin
            state_s = ST_PROC;
        end else begin
            state_s = ST_HB;
        end
    end

    // Test pattern starts lit on entry and toggles per tick while testing
    always_comb begin
        pat_s = pat_r;
        if ((state_s == ST_TEST) && (state_r != ST_TEST)) begin
            pat_s = 1'b1;
        end else if ((state_r == ST_TEST) && tick_r) begin
            pat_s = ~pat_r;
        end else begin
            pat_s = pat_r;
        end
    end

    // Output selection for the upcoming state
    always_comb begin
        leds_s = hb_s;
        src_s  = 2'd0;
        case (state_s)
            ST_HB: begin
                leds_s = hb_s;
                src_s  = 2'd0;
            end
            ST_PROC: begin
                leds_s = proc_q_s;
                src_s  = 2'd1;
            end
            ST_TEST: begin
                leds_s = {10{pat_s}};
                src_s  = 2'd2;
            end
            default: begin
                leds_s = hb_s;
                src_s  = 2'd0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r    <= '0;
            tick_r   <= 1'b0;
            sync1_r  <= 4'b1111;
            sync2_r  <= 4'b1111;
            db_r     <= 4'b1111;
            cnt_r    <= '0;
            kp_r     <= 4'b0000;
            hb_r     <= 10'd0;
            proc_q_r <= 10'd0;
            hold_r   <= '0;
            pat_r    <= 1'b0;
        end else begin
            div_r    <= div_s;
            tick_r   <= (div_s == DIV_LAST);
            sync1_r  <= key_n;
            sync2_r  <= sync1_r;
            db_r     <= db_s;
            cnt_r    <= cnt_s;
            kp_r     <= kp_s;
            hb_r     <= hb_s;
            proc_q_r <= proc_q_s;
            hold_r   <= hold_s;
            pat_r    <= pat_s;
        end
    end

    // State register and registered LED drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_HB;
            leds_r  <= 10'd0;
            src_r   <= 2'd0;
        end else begin
            state_r <= state_s;
            leds_r  <= leds_s;
            src_r   <= src_s;
        end
    end

    assign leds         = leds_r;
    assign src          = src_r;
    assign keys_pressed = kp_r;
    assign tick         = tick_r;

endmodule

// File: tb/tb_led_scheduler.sv
// Bench for led_scheduler: directed scenarios plus random stimulus, checked every
// cycle against a behavioural model derived from sample histories and owner rules.
module tb_led_scheduler;

    localparam int TD   = 4;
    localparam int DEB  = 3;
    localparam int HOLD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic [9:0] proc_leds = 10'd0;
    logic       proc_wr = 1'b0;
    logic [9:0] leds;
    logic [1:0] src;
    logic [3:0] keys_pressed;
    logic       tick;

    led_scheduler #(.TICK_DIV(TD), .DEB_CYCLES(DEB), .HOLD_TICKS(HOLD)) dut (
        .clk(clk), .rst(rst), .key_n(key_n), .proc_leds(proc_leds), .proc_wr(proc_wr),
        .leds(leds), .src(src), .keys_pressed(keys_pressed), .tick(tick)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model state: edges since reset, raw key samples, synced history, logical registers
    int         ecnt = 0;
    logic [3:0] raw_q[$];
    logic [3:0] syn_q[$];
    logic [3:0] m_db = 4'hF;
    int         m_hb = 0, m_hold = 0, m_pq = 0, m_owner = 0;
    bit         m_pat = 1'b0;
    bit         tick_b, flip;
    int         new_owner;
    logic [3:0] m_kp;
    logic [9:0] e_leds;

    bit         pin_en = 1'b0, pin_l = 1'b0;
    logic [9:0] pin_leds = 10'd0;
    logic [1:0] pin_src = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, ecnt, act, exp);
        end
    endtask

    // Reference model and per-cycle comparison
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ecnt = 0; m_hb = 0; m_hold = 0; m_pq = 0; m_owner = 0; m_pat = 1'b0;
            m_db = 4'hF;
            raw_q.delete();
            syn_q.delete();
            #1;
            chk("rst_leds", 32'(leds), 32'd0);
            chk("rst_src", 32'(src), 32'd0);
            chk("rst_keys", 32'(keys_pressed), 32'd0);
            chk("rst_tick", 32'(tick), 32'd0);
        end else begin
            tick_b = (ecnt % TD == TD - 1);
            ecnt++;
            raw_q.push_back(key_n);
            syn_q.push_back((ecnt >= 3) ? raw_q[ecnt-3] : 4'hF);
            if (ecnt >= DEB) begin
                for (int i = 0; i < 4; i++) begin
                    flip = 1'b1;
                    for (int j = ecnt - DEB + 1; j <= ecnt; j++)
                        if (syn_q[j-1][i] == m_db[i]) flip = 1'b0;
                    if (flip) m_db[i] = ~m_db[i];
                end
            end
            m_kp = ~m_db;
            if (m_kp[0]) m_hb = 0;
            else if (tick_b) m_hb = (m_hb + 1) % 1024;
            if (proc_wr) begin
                m_pq = int'(proc_leds);
                m_hold = HOLD;
            end else if (tick_b && m_hold > 0) begin
                m_hold--;
            end
            new_owner = m_kp[1] ? 2 : ((m_hold > 0) ? 1 : 0);
            if (new_owner == 2) m_pat = (m_owner != 2) ? 1'b1 : (tick_b ? ~m_pat : m_pat);
            m_owner = new_owner;
            e_leds = (m_owner == 0) ? 10'(m_hb) : (m_owner == 1) ? 10'(m_pq) : {10{m_pat}};
            #1;
            chk("leds", 32'(leds), 32'(e_leds));
            chk("src", 32'(src), 32'(m_owner));
            chk("keys", 32'(keys_pressed), 32'(m_kp));
            chk("tick", 32'(tick), 32'(ecnt % TD == TD - 1));
            if (pin_en) begin
                chk("pin_src", 32'(src), 32'(pin_src));
                if (pin_l) chk("pin_leds", 32'(leds), 32'(pin_leds));
            end
        end
    end

    task automatic pin(input logic [9:0] l, input logic [1:0] s, input bit with_leds);
        pin_leds = l; pin_src = s; pin_l = with_leds; pin_en = 1'b1;
        @(negedge clk);
        pin_en = 1'b0;
    endtask

    task automatic wait_edge(input int e);
        int guard;
        guard = 0;
        while (ecnt < e - 1) begin
            @(negedge clk);
            guard++;
            if (guard > 10000) begin
                $display("FAIL wait_edge target=%0d stuck at %0d", e, ecnt);
                $fatal(1);
            end
        end
    endtask

    initial begin
        int e0;
        int guard;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_edge(12);   pin(10'd3, 2'd0, 1'b1);
        wait_edge(4092); pin(10'h3FF, 2'd0, 1'b1);
        wait_edge(4096); pin(10'd0, 2'd0, 1'b1);

        // processor write and rewrite during hold
        repeat (3) @(negedge clk);
        proc_leds = 10'h2A5; proc_wr = 1'b1; pin(10'h2A5, 2'd1, 1'b1); proc_wr = 1'b0;
        repeat (5) @(negedge clk);
        proc_leds = 10'h155; proc_wr = 1'b1; pin(10'h155, 2'd1, 1'b1); proc_wr = 1'b0;
        repeat (12) @(negedge clk);

        // short glitch is filtered, long press enters TEST
        key_n[1] = 1'b0; repeat (2) @(negedge clk); key_n[1] = 1'b1;
        repeat (8) @(negedge clk);
        key_n[1] = 1'b0; e0 = ecnt;
        wait_edge(e0 + 5); pin(10'h3FF, 2'd2, 1'b1);
        repeat (6) @(negedge clk);

        // release with a write landing in TEST: PROC shown on exit
        key_n[1] = 1'b1; e0 = ecnt;
        repeat (2) @(negedge clk);
        proc_leds = 10'h0F0; proc_wr = 1'b1; @(negedge clk); proc_wr = 1'b0;
        wait_edge(e0 + 5); pin(10'h0F0, 2'd1, 1'b1);
        repeat (12) @(negedge clk);

        // release after hold expired: back to heartbeat
        proc_leds = 10'h3C3; proc_wr = 1'b1; @(negedge clk); proc_wr = 1'b0;
        key_n[1] = 1'b0;
        repeat (16) @(negedge clk);
        key_n[1] = 1'b1; e0 = ecnt;
        wait_edge(e0 + 5); pin(10'd0, 2'd0, 1'b0);
        repeat (8) @(negedge clk);

        // heartbeat clear coinciding with a tick
        while ((ecnt + 5) % TD != 0) @(negedge clk);
        key_n[0] = 1'b0; e0 = ecnt;
        wait_edge(e0 + 5); pin(10'd0, 2'd0, 1'b1);
        repeat (10) @(negedge clk);
        pin(10'd0, 2'd0, 1'b1);
        key_n[0] = 1'b1;
        repeat (20) @(negedge clk);

        // write coinciding with the tick that would take hold from 1 to 0
        proc_leds = 10'h1A1; proc_wr = 1'b1; @(negedge clk); proc_wr = 1'b0;
        guard = 0;
        while (!(m_hold == 1 && (ecnt % TD == TD - 1))) begin
            @(negedge clk);
            guard++;
            if (guard > 40) begin
                $display("FAIL reload_align never reached hold=1 on tick");
                $fatal(1);
            end
        end
        proc_leds = 10'h2E7; proc_wr = 1'b1; pin(10'h2E7, 2'd1, 1'b1); proc_wr = 1'b0;
        repeat (12) @(negedge clk);

        // random traffic with one reset in the middle
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (n == 1500) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            proc_wr = ($urandom_range(7) == 0);
            proc_leds = 10'($urandom);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(5) == 0) key_n[k] = ~key_n[k];
        end
        @(negedge clk);
        proc_wr = 1'b0;
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
